// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register for the 64-bit RISC-V core.
//
// Registers the decoded ID instruction (PC, operands, immediate, register
// addresses, control) for EX. Also:
//   - forwards the WB write into the captured operands, because the register
//     file reads combinationally and does not see a same-cycle write;
//   - detects load-use hazards against the instruction in EX and inserts one
//     bubble per hazard;
//   - holds under EX back-pressure, keeping the held operands current with WB;
//   - kills the ID->EX transfer on a branch flush.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   id_*                   ID-stage instruction fields (id_valid qualifies)
//   wb_regwrite/rd/data    register-file write port of the WB stage
//   ex_ready               EX can accept a new instruction
//   flush                  branch taken, insert a bubble
//   id_stall               hold PC and IF/ID this cycle (combinational)
//   ex_*                   registered EX-slot contents (ex_valid qualifies)
//
// Optional build macro IDEX_PERF_CNT_EN adds the perf_bubbles and
// perf_flushes counters (32-bit, wrapping, cleared by reset).
//
// ctrl bus: [7]RegWrite [6]MemRead [5]MemWrite [4]MemtoReg [3]ALUSrc
//           [2]Branch [1:0]ALUOp

module id_ex_stage #(
  parameter int XLEN   = 64,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [63:0]       id_pc,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_regwrite,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [63:0]       ex_pc,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_flushes
`endif
);

  localparam int MEMREAD = 6;

  logic            wb_live;
  logic            byp1, byp2;
  logic            ref1, ref2;
  logic [XLEN-1:0] op1, op2;
  logic            hazard;

  // WB write to x0 is architecturally discarded, so it never forwards.
  assign wb_live = wb_regwrite && (wb_rd != '0);

  assign byp1 = wb_live && (wb_rd == id_rs1);
  assign byp2 = wb_live && (wb_rd == id_rs2);
  assign op1  = byp1 ? wb_data : id_rd1;
  assign op2  = byp2 ? wb_data : id_rd2;

  // Held operands would otherwise go stale while EX is frozen.
  assign ref1 = wb_live && (wb_rd == ex_rs1);
  assign ref2 = wb_live && (wb_rd == ex_rs2);

  assign hazard = id_valid && ex_valid && ex_ctrl[MEMREAD] && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign id_stall = hazard || !ex_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= '0;
    end else if (!ex_ready) begin
      // Hold beats hazard: EX is frozen, only operand refresh happens.
      if (ref1) ex_rd1 <= wb_data;
      if (ref2) ex_rd2 <= wb_data;
    end else if (hazard) begin
      // One bubble; the bubble itself clears the hazard next cycle.
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_rd1   <= op1;
      ex_rd2   <= op2;
      ex_imm   <= id_imm;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else begin
      if (flush)                        perf_flushes <= perf_flushes + 32'd1;
      if (!flush && ex_ready && hazard) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with constant
// expectations, then randomized traffic checked against a reference model
// of the EX slot.
module tb_id_ex_stage;
  localparam int XLEN = 64, RA_W = 5, CTRL_W = 8;

  logic              clk = 1'b0;
  logic              reset, id_valid, wb_regwrite, ex_ready, flush;
  logic [63:0]       id_pc;
  logic [XLEN-1:0]   id_rd1, id_rd2, id_imm, wb_data;
  logic [RA_W-1:0]   id_rs1, id_rs2, id_rd, wb_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_stall, ex_valid;
  logic [63:0]       ex_pc;
  logic [XLEN-1:0]   ex_rd1, ex_rd2, ex_imm;
  logic [RA_W-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0]       perf_bubbles, perf_flushes;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl)
`ifdef IDEX_PERF_CNT_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  typedef struct packed {
    logic              valid;
    logic [63:0]       pc;
    logic [XLEN-1:0]   rd1, rd2, imm;
    logic [RA_W-1:0]   rs1, rs2, rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t obs, m, snap;
  assign obs = {ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl};

  int unsigned m_bub, m_fl;
  int asserts = 0, fails = 0;

  // Value a reader of register a would see this cycle once the WB write lands.
  function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] a, input logic [XLEN-1:0] v);
    return (wb_regwrite && wb_rd != 0 && wb_rd == a) ? wb_data : v;
  endfunction

  // Load in EX whose result is needed by the valid ID instruction.
  function automatic logic m_hazard();
    return id_valid && m.valid && m.ctrl[6] && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  // Advance one clock: model takes the spec's next state from current inputs.
  task automatic tick();
    ex_t n;
    n = m;
    if (reset) begin
      n = '0; m_bub = 0; m_fl = 0;
    end else if (flush) begin
      n = '0; m_fl = m_fl + 1;
    end else if (!ex_ready) begin
      n.rd1 = fwd(m.rs1, m.rd1);
      n.rd2 = fwd(m.rs2, m.rd2);
    end else if (m_hazard()) begin
      n = '0; m_bub = m_bub + 1;
    end else begin
      n.valid = id_valid; n.pc = id_pc; n.imm = id_imm;
      n.rd1 = fwd(id_rs1, id_rd1); n.rd2 = fwd(id_rs2, id_rd2);
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
      n.ctrl = id_valid ? id_ctrl : '0;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic set_id(input logic v, input logic [RA_W-1:0] s1, input logic [XLEN-1:0] d1,
                        input logic [RA_W-1:0] s2, input logic [XLEN-1:0] d2,
                        input logic [RA_W-1:0] d, input logic [CTRL_W-1:0] c);
    id_valid = v; id_rs1 = s1; id_rd1 = d1; id_rs2 = s2; id_rd2 = d2; id_rd = d; id_ctrl = c;
    id_pc = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; ex_ready = 1; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    set_id(1, 3, 64'h5, 4, 64'h6, 2, 8'hFF);
    tick(); tick();
    reset = 0;
    asserts++; if (obs !== '0) begin fails++; $display("FAIL reset_state got %h want 0", obs); end
    id_valid = 0; #1;
    asserts++; if (id_stall !== 1'b0) begin fails++; $display("FAIL reset_stall_ready got %b want 0", id_stall); end
    ex_ready = 0; #1;
    asserts++; if (id_stall !== 1'b1) begin fails++; $display("FAIL reset_stall_notready got %b want 1", id_stall); end
    ex_ready = 1; #1;
`ifdef IDEX_PERF_CNT_EN
    asserts++; if (perf_bubbles !== 0 || perf_flushes !== 0) begin fails++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_bubbles, perf_flushes); end
`endif
  endtask

  task automatic test_capture();
    set_id(1, 9, 64'd9, 21, 64'd21, 5, 8'h80); #1;
    asserts++; if (id_stall !== 1'b0) begin fails++; $display("FAIL capture_stall got %b want 0", id_stall); end
    tick();
    asserts++;
    if (ex_valid !== 1'b1 || ex_rd1 !== 64'd9 || ex_rd2 !== 64'd21 || ex_rd !== 5 || ex_ctrl !== 8'h80) begin
      fails++; $display("FAIL capture got v=%b rd1=%0h rd2=%0h rd=%0d ctrl=%h want 1/9/15/5/80", ex_valid, ex_rd1, ex_rd2, ex_rd, ex_ctrl);
    end
    asserts++; if (obs !== m) begin fails++; $display("FAIL capture_model got %h want %h", obs, m); end
  endtask

  task automatic test_bypass();
    set_id(1, 9, 64'd9, 21, 64'd21, 5, 8'h80);
    wb_regwrite = 1; wb_rd = 9; wb_data = 64'h77;
    tick();
    asserts++; if (ex_rd1 !== 64'h77 || ex_rd2 !== 64'd21) begin fails++; $display("FAIL bypass_op1 got %h/%h want 77/15", ex_rd1, ex_rd2); end
    set_id(1, 0, 64'd9, 21, 64'd21, 5, 8'h80);
    wb_rd = 0; wb_data = 64'h55;
    tick();
    asserts++; if (ex_rd1 !== 64'd9) begin fails++; $display("FAIL bypass_x0 got %h want 9", ex_rd1); end
    set_id(1, 3, 64'd3, 21, 64'd21, 5, 8'h80);
    wb_rd = 21; wb_data = 64'hBEEF;
    tick();
    asserts++; if (ex_rd1 !== 64'd3 || ex_rd2 !== 64'hBEEF) begin fails++; $display("FAIL bypass_op2 got %h/%h want 3/beef", ex_rd1, ex_rd2); end
    wb_regwrite = 0;
  endtask

  task automatic test_load_use();
    set_id(1, 1, 64'h1, 2, 64'h2, 7, 8'hD0);
    tick();
    set_id(1, 3, 64'h3, 7, 64'h70, 8, 8'h80); #1;
    asserts++; if (id_stall !== 1'b1) begin fails++; $display("FAIL loaduse_stall got %b want 1", id_stall); end
    tick();
    asserts++; if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin fails++; $display("FAIL loaduse_bubble got v=%b ctrl=%h want 0/00", ex_valid, ex_ctrl); end
    asserts++; if (id_stall !== 1'b0) begin fails++; $display("FAIL loaduse_release got %b want 0", id_stall); end
    tick();
    asserts++; if (ex_valid !== 1'b1 || ex_rd !== 8 || ex_rd2 !== 64'h70) begin fails++; $display("FAIL loaduse_retry got v=%b rd=%0d rd2=%h want 1/8/70", ex_valid, ex_rd, ex_rd2); end
`ifdef IDEX_PERF_CNT_EN
    asserts++; if (perf_bubbles !== 32'd1) begin fails++; $display("FAIL perf_bubbles got %0d want 1", perf_bubbles); end
`endif
  endtask

  task automatic test_back_pressure();
    set_id(1, 4, 64'h11, 6, 64'h22, 9, 8'h88);
    tick();
    snap = obs;
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'($urandom_range(1, 31)), {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom}, 5'($urandom), 8'($urandom)); #1;
      asserts++; if (id_stall !== 1'b1) begin fails++; $display("FAIL hold_stall[%0d] got %b want 1", i, id_stall); end
      tick();
      asserts++; if (obs !== snap) begin fails++; $display("FAIL hold_frozen[%0d] got %h want %h", i, obs, snap); end
    end
    wb_regwrite = 1; wb_rd = 4; wb_data = 64'hAB;
    tick();
    asserts++; if (ex_rd1 !== 64'hAB || ex_rd2 !== 64'h22) begin fails++; $display("FAIL hold_refresh1 got %h/%h want ab/22", ex_rd1, ex_rd2); end
    wb_rd = 6; wb_data = 64'hCD;
    tick();
    asserts++; if (ex_rd1 !== 64'hAB || ex_rd2 !== 64'hCD) begin fails++; $display("FAIL hold_refresh2 got %h/%h want ab/cd", ex_rd1, ex_rd2); end
    wb_regwrite = 0; ex_ready = 1;
  endtask

  task automatic test_flush();
    set_id(1, 1, 64'h1, 2, 64'h2, 7, 8'hD0);
    tick();
    set_id(1, 7, 64'h7, 3, 64'h3, 8, 8'h80);
    ex_ready = 0; flush = 1; #1;
    asserts++; if (id_stall !== 1'b1) begin fails++; $display("FAIL flush_stall got %b want 1", id_stall); end
    tick();
    asserts++; if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || obs !== '0) begin fails++; $display("FAIL flush_bubble got %h want 0", obs); end
`ifdef IDEX_PERF_CNT_EN
    asserts++; if (perf_flushes !== 32'd1 || perf_bubbles !== 32'd1) begin fails++; $display("FAIL perf_flush got %0d/%0d want 1/1", perf_flushes, perf_bubbles); end
`endif
    flush = 0; ex_ready = 1;
  endtask

  task automatic test_reset_mid();
    set_id(1, 2, 64'h2, 3, 64'h3, 4, 8'h8C);
    tick();
    asserts++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL midreset_setup got %b want 1", ex_valid); end
    ex_ready = 0; reset = 1;
    tick();
    reset = 0; ex_ready = 1;
    asserts++; if (obs !== '0) begin fails++; $display("FAIL midreset got %h want 0", obs); end
`ifdef IDEX_PERF_CNT_EN
    asserts++; if (perf_bubbles !== 0 || perf_flushes !== 0) begin fails++; $display("FAIL midreset_perf got %0d/%0d want 0/0", perf_bubbles, perf_flushes); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 8);
      ex_ready = ($urandom_range(0, 99) < 75);
      wb_regwrite = $urandom_range(0, 1);
      wb_rd = 5'($urandom_range(0, 7)); wb_data = {$urandom, $urandom};
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
             5'($urandom_range(0, 7)), {$urandom, $urandom}, 5'($urandom_range(0, 7)), 8'($urandom));
      #1;
      asserts++; if (id_stall !== (m_hazard() || !ex_ready)) begin fails++; $display("FAIL rand_stall[%0d] got %b want %b", i, id_stall, m_hazard() || !ex_ready); end
      tick();
      asserts++; if (obs !== m) begin fails++; $display("FAIL rand_ex[%0d] got %h want %h", i, obs, m); end
`ifdef IDEX_PERF_CNT_EN
      asserts++; if (perf_bubbles !== m_bub || perf_flushes !== m_fl) begin fails++; $display("FAIL rand_perf[%0d] got %0d/%0d want %0d/%0d", i, perf_bubbles, perf_flushes, m_bub, m_fl); end
`endif
    end
    reset = 0; flush = 0; ex_ready = 1; wb_regwrite = 0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bypass();
    test_load_use();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 64-bit RISC-V core.
- Captures the register-file read data (readData1/readData2), decoded fields, immediate and control bits, and presents them to EX.
- Applies write-back bypass, because the register file reads combinationally and is not sensitive to same-cycle writes.
- Detects load-use hazards and inserts bubbles. Honours downstream back-pressure and branch flushes.

Parameters:
XLEN, 64, datapath width
RA_W, 5, register address width
CTRL_W, 8, control bus width: [7]RegWrite [6]MemRead [5]MemWrite [4]MemtoReg [3]ALUSrc [2]Branch [1:0]ALUOp

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_pc  in  64  PC of ID instruction
id_rd1  in  XLEN  register file readData1
id_rd2  in  XLEN  register file readData2
id_rs1  in  RA_W  source 1 address
id_rs2  in  RA_W  source 2 address
id_rd  in  RA_W  destination address
id_imm  in  XLEN  sign-extended immediate
id_ctrl  in  CTRL_W  decoded control
wb_regwrite  in  1  WB writing register file this cycle
wb_rd  in  RA_W  WB destination
wb_data  in  XLEN  WB write data
ex_ready  in  1  EX can accept a new instruction
flush  in  1  branch taken; kill ID->EX transfer
id_stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX slot holds a real instruction
ex_pc, ex_rd1, ex_rd2, ex_imm  out  64/XLEN  registered copies
ex_rs1, ex_rs2, ex_rd  out  RA_W  registered addresses
ex_ctrl  out  CTRL_W  registered control

Behaviour:
- Reset: every ex_* output goes to 0, including ex_valid=0 and ex_ctrl=0. id_stall then depends only on ex_ready.
- Bypass: bypass1 = wb_regwrite && wb_rd!=0 && wb_rd==id_rs1. When bypass1 is true, the captured operand 1 is wb_data, otherwise id_rd1. Operand 2 works the same way using id_rs2. x0 is never bypassed.
- Load-use hazard: hazard = id_valid && ex_valid && ex_ctrl[6] && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- id_stall is combinational: id_stall = hazard || !ex_ready.
- Register update per posedge clk, priority highest first:
  1. reset: clear all ex_* outputs.
  2. flush: insert bubble. ex_valid=0, ex_ctrl=0, data fields zeroed. Flush overrides both hold and hazard.
  3. !ex_ready (hold): all fields keep their value, except held-operand refresh. If wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1, ex_rd1<=wb_data; ex_rs2 / ex_rd2 likewise.
  4. hazard: insert bubble as in step 2. The ID instruction is retried next cycle. The hazard clears automatically because EX now holds a bubble, so there is exactly one bubble per load-use.
  5. Otherwise: capture the ID fields with bypass applied. ex_valid<=id_valid. If !id_valid, ex_ctrl<=0.
- Latency: 1 cycle from ID to EX outputs.
- No combinational path from id_* to ex_* outputs.
- Simultaneous hold and hazard: hold wins (EX is frozen). id_stall stays 1.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- When defined, adds outputs perf_bubbles (32) and perf_flushes (32):
  - perf_bubbles increments on every hazard bubble.
  - perf_flushes increments on every cycle with flush=1.
  - Both cleared by reset; both wrap modulo 2^32.
- When not defined: ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Normal capture: reset, then id_valid=1, id_rs1=9, id_rd1=9, id_rs2=21, id_rd2=21, id_rd=5, id_ctrl=8'h80, ex_ready=1 -> next cycle ex_valid=1, ex_rd1=9, ex_rd2=21, ex_rd=5, id_stall=0.
- WB bypass: id_rs1=9, id_rd1=9, wb_regwrite=1, wb_rd=9, wb_data=64'h77 -> ex_rd1=64'h77. Repeat with wb_rd=0 and id_rs1=0 -> ex_rd1=id_rd1.
- Load-use: EX holds MemRead with ex_rd=7; ID has id_rs2=7 -> id_stall=1 that cycle, then ex_valid=0 and ex_ctrl=0. The following cycle the ID instruction is captured and id_stall=0.
- Back-pressure: ex_ready=0 for 3 cycles with changing ID inputs -> ex_* unchanged and id_stall=1. During the hold, wb writes 64'hAB to ex_rs1 -> ex_rd1=64'hAB.
- Flush priority: flush=1 together with hazard and ex_ready=0 -> next cycle ex_valid=0 and ex_ctrl=0.
- Reset mid-operation: reset asserted while holding valid EX content -> all ex_* outputs 0 next cycle. With IDEX_PERF_CNT_EN defined, the counters read 0 after reset and perf_bubbles=1 after a single load-use.
